// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, funct3 constants and lane-mask helper for the load/store unit.
// Revision 1.0
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Byte-enable pattern for an access of the given size, anchored at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] mask;
    case (size)
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_if.sv
// lsu_if: core request/response and data-memory bus of the load/store unit.
// Revision 1.0
`default_nettype none

interface lsu_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic [XLEN-1:0] mem_address;
  logic [XLEN-1:0] mem_WriteData;
  logic            mem_MemWrite;
  logic            mem_MemRead;
  logic [XLEN-1:0] mem_ReadData;

  // The master side is the core plus the memory returning read data.
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ReadData,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_address, mem_WriteData, mem_MemWrite, mem_MemRead
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ReadData,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_address, mem_WriteData, mem_MemWrite, mem_MemRead
  );
endinterface

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: load lane extract/extend and store lane merge on one doubleword.
// Revision 1.0
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] dword,
  input  logic [XLEN-1:0] wdata,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_data
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] wshift;
  logic [7:0]      lane_mask;

  always_comb begin
    shifted = dword >> {offset, 3'b000};
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      F3_H:    load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_BU:   load_data = {{(XLEN-8){1'b0}},         shifted[7:0]};
      F3_HU:   load_data = {{(XLEN-16){1'b0}},        shifted[15:0]};
      F3_WU:   load_data = {{(XLEN-32){1'b0}},        shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  // Alignment is checked before this path is used, so the shifted mask never spills past lane 7.
  always_comb begin
    wshift     = wdata << {offset, 3'b000};
    lane_mask  = size_mask(funct3[1:0]) << offset;
    store_data = dword;
    for (int i = 0; i < XLEN / 8; i++) begin
      if (lane_mask[i]) begin
        store_data[8*i +: 8] = wshift[8*i +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// load_store_unit: maps sized loads/stores onto aligned doubleword memory accesses (RMW for partial stores).
// Revision 1.0
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int ADDR_LIMIT = 8192
) (
  input  logic  clk,
  input  logic  rst,
  lsu_if.slave  bus
);

  lsu_state_e      state;
  logic            r_write;
  logic [2:0]      r_funct3;
  logic [2:0]      r_offset;
  logic [XLEN-1:0] r_wdata;

  logic            r_resp_valid;
  logic            r_resp_err;
  logic [XLEN-1:0] r_resp_rdata;
  logic [XLEN-1:0] r_mem_address;
  logic [XLEN-1:0] r_mem_wdata;
  logic            r_mem_read;
  logic            r_mem_write;

  logic            w_accept;
  logic            w_illegal;
  logic            w_misaligned;
  logic            w_out_of_range;
  logic            w_error;
  logic [1:0]      w_size;
  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_store_data;

  assign w_accept       = bus.req_valid && (state == IDLE);
  assign w_size         = bus.req_funct3[1:0];
  assign w_illegal      = (bus.req_funct3 == 3'b111) || (bus.req_write && bus.req_funct3[2]);
  assign w_out_of_range = bus.req_addr >= XLEN'(ADDR_LIMIT);
  assign w_error        = w_illegal || w_misaligned || w_out_of_range;

  always_comb begin
    case (w_size)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = bus.req_addr[0];
      2'd2:    w_misaligned = |bus.req_addr[1:0];
      default: w_misaligned = |bus.req_addr[2:0];
    endcase
  end

  // Read data is only consumed in READ, where it feeds both the load result and the store merge.
  lsu_lane_align #(
    .XLEN (XLEN)
  ) u_lane_align (
    .dword      (bus.mem_ReadData),
    .wdata      (r_wdata),
    .offset     (r_offset),
    .funct3     (r_funct3),
    .load_data  (w_load_data),
    .store_data (w_store_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      r_write       <= 1'b0;
      r_funct3      <= 3'b000;
      r_offset      <= 3'b000;
      r_wdata       <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= '0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (w_accept) begin
            r_write  <= bus.req_write;
            r_funct3 <= bus.req_funct3;
            r_offset <= bus.req_addr[2:0];
            r_wdata  <= bus.req_wdata;
            if (w_error) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
              state        <= RESP;
            end else if (bus.req_write && (w_size == 2'd3)) begin
              r_mem_address <= {bus.req_addr[XLEN-1:3], 3'b000};
              r_mem_wdata   <= bus.req_wdata;
              r_mem_write   <= 1'b1;
              state         <= WRITE;
            end else begin
              r_mem_address <= {bus.req_addr[XLEN-1:3], 3'b000};
              r_mem_read    <= 1'b1;
              state         <= READ;
            end
          end
        end
        READ: begin
          r_mem_read <= 1'b0;
          if (r_write) begin
            r_mem_wdata <= w_store_data;
            r_mem_write <= 1'b1;
            state       <= WRITE;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_load_data;
            state        <= RESP;
          end
        end
        WRITE: begin
          r_mem_write  <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
          state        <= RESP;
        end
        RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = (state == IDLE);
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_err      = r_resp_err;
  assign bus.resp_rdata    = r_resp_rdata;
  assign bus.mem_address   = r_mem_address;
  assign bus.mem_WriteData = r_mem_wdata;
  assign bus.mem_MemRead   = r_mem_read;
  assign bus.mem_MemWrite  = r_mem_write;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: byte-level reference model and per-cycle checker for load_store_unit.
// Revision 1.0
`default_nettype none

module tb_load_store_unit;

  typedef struct {
    bit          err;
    logic [63:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
    logic [63:0] base;
    logic [63:0] wdw;
    int          acc;
    bit          commit;
  } exp_t;

  logic clk;
  logic rst;
  lsu_if #(.XLEN(64)) bus ();

  load_store_unit #(
    .XLEN       (64),
    .ADDR_LIMIT (8192)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [63:0] emem [0:1023];
  logic [7:0]  ref_mem [0:8191];
  exp_t        q [$];
  int          cyc;
  int          errors;
  int          checks;
  int          nrd;
  int          nwr;
  logic [63:0] last_rdata;
  logic        last_err;
  int          last_lat;
  logic [63:0] last_waddr;
  logic [63:0] last_wdata;

  assign bus.mem_ReadData = emem[bus.mem_address[12:3]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour computed byte by byte from a flat byte-addressed memory.
  function automatic exp_t model(bit w, logic [2:0] f3, logic [63:0] addr, logic [63:0] wd);
    exp_t e;
    int n;
    int off;
    logic [63:0] v;
    n   = 1 << f3[1:0];
    off = int'(addr[2:0]);
    e   = '{err: 1'b0, rdata: 64'd0, lat: 0, nrd: 0, nwr: 0, base: 64'd0,
            wdw: 64'd0, acc: 0, commit: 1'b0};
    e.base = {addr[63:3], 3'b000};
    e.err  = (f3 == 3'd7) || (w && f3 > 3'd3) || ((addr % 64'(n)) != 0) || (addr >= 64'd8192);
    if (e.err) begin
      e.lat = 1;
      return e;
    end
    v = 64'd0;
    if (!w) begin
      for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(addr) + i]) << (8 * i));
      if (f3 < 3'd4 && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
      e.rdata = v;
      e.lat   = 2;
      e.nrd   = 1;
    end else begin
      for (int j = 0; j < 8; j++) begin
        if (j >= off && j < off + n) v[8*j +: 8] = wd[8*(j-off) +: 8];
        else                         v[8*j +: 8] = ref_mem[int'(e.base) + j];
      end
      e.wdw    = v;
      e.commit = 1'b1;
      e.nwr    = 1;
      e.nrd    = (n < 8) ? 1 : 0;
      e.lat    = (n < 8) ? 3 : 2;
    end
    return e;
  endfunction

  // Environment memory, cycle counter and the per-cycle compare process.
  initial begin
    exp_t e;
    cyc = 0;
    nrd = 0;
    nwr = 0;
    for (int d = 0; d < 1024; d++) emem[d] = {$urandom, $urandom};
    emem[2] = 64'h8877665544332211;
    for (int d = 0; d < 1024; d++)
      for (int b = 0; b < 8; b++) ref_mem[d*8 + b] = emem[d][8*b +: 8];
    forever begin
      @(posedge clk);
      if (bus.mem_MemWrite) emem[bus.mem_address[12:3]] = bus.mem_WriteData;
      cyc++;
      @(negedge clk);
      if (!rst) begin
        q.delete();
        nrd = 0;
        nwr = 0;
      end else begin
        chk("strobe_excl", 64'(bus.mem_MemRead & bus.mem_MemWrite), 64'd0);
        chk("req_ready", 64'(bus.req_ready), 64'(q.size() == 0));
        if (bus.mem_MemRead) begin
          nrd++;
          if (q.size() == 0) chk("read_unexpected", 64'(bus.mem_MemRead), 64'd0);
          else chk("read_addr", bus.mem_address, q[0].base);
        end
        if (bus.mem_MemWrite) begin
          nwr++;
          last_waddr = bus.mem_address;
          last_wdata = bus.mem_WriteData;
          if (q.size() == 0) chk("write_unexpected", 64'(bus.mem_MemWrite), 64'd0);
          else begin
            chk("write_addr", bus.mem_address, q[0].base);
            chk("write_data", bus.mem_WriteData, q[0].wdw);
          end
        end
        if (bus.resp_valid) begin
          if (q.size() == 0) chk("resp_unexpected", 64'(bus.resp_valid), 64'd0);
          else begin
            e = q.pop_front();
            chk("resp_err", 64'(bus.resp_err), 64'(e.err));
            chk("resp_rdata", bus.resp_rdata, e.rdata);
            chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            chk("read_cycles", 64'(nrd), 64'(e.nrd));
            chk("write_cycles", 64'(nwr), 64'(e.nwr));
            last_rdata = bus.resp_rdata;
            last_err   = bus.resp_err;
            last_lat   = cyc - e.acc + 1;
            if (e.commit)
              for (int j = 0; j < 8; j++) ref_mem[int'(e.base) + j] = e.wdw[8*j +: 8];
          end
          nrd = 0;
          nwr = 0;
        end
      end
    end
  end

  task automatic issue(input bit w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("ready_timeout", 64'(bus.req_ready), 64'd1);
      return;
    end
    last_rdata     = 'x;
    last_err       = 1'bx;
    last_lat       = -1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    e = model(w, f3, a, wd);
    @(posedge clk);
    #1;
    e.acc = cyc;
    q.push_back(e);
    bus.req_valid  = 1'b0;
    bus.req_addr   = {$urandom, $urandom};
    bus.req_wdata  = {$urandom, $urandom};
    bus.req_funct3 = 3'($urandom_range(0, 7));
  endtask

  task automatic do_req(input bit w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
    int n;
    issue(w, f3, a, wd);
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      chk("resp_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          w;
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] mask;
    int          sel;
    int          n;
    errors = 0;
    checks = 0;
    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 64'd0;
    bus.req_wdata  = 64'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready",      64'(bus.req_ready),    64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid),   64'd0);
    chk("rst_resp_rdata", bus.resp_rdata,        64'd0);
    chk("rst_resp_err",   64'(bus.resp_err),     64'd0);
    chk("rst_memread",    64'(bus.mem_MemRead),  64'd0);
    chk("rst_memwrite",   64'(bus.mem_MemWrite), 64'd0);
    chk("rst_address",    bus.mem_address,       64'd0);
    chk("rst_wdata",      bus.mem_WriteData,     64'd0);
    rst = 1'b1;

    do_req(1'b0, 3'b011, 64'h10, 64'd0);
    chk("ld_lit", last_rdata, 64'h8877665544332211);
    chk("ld_lat", 64'(last_lat), 64'd2);
    do_req(1'b0, 3'b000, 64'h17, 64'd0);
    chk("lb_lit", last_rdata, 64'hFFFFFFFFFFFFFF88);
    do_req(1'b0, 3'b100, 64'h17, 64'd0);
    chk("lbu_lit", last_rdata, 64'h88);
    do_req(1'b1, 3'b000, 64'h12, 64'hAB);
    chk("sb_addr_lit", last_waddr, 64'h10);
    chk("sb_data_lit", last_wdata, 64'h8877665544AB2211);
    chk("sb_lat", 64'(last_lat), 64'd3);
    do_req(1'b0, 3'b010, 64'h06, 64'd0);
    chk("lw_misalign_err", 64'(last_err), 64'd1);
    chk("lw_misalign_lat", 64'(last_lat), 64'd1);
    do_req(1'b0, 3'b111, 64'h10, 64'd0);
    chk("f3_illegal_err", 64'(last_err), 64'd1);
    do_req(1'b1, 3'b110, 64'h10, 64'h1234);
    chk("sw_f3_110_err", 64'(last_err), 64'd1);

    // Reset during the write cycle of a partial store.
    issue(1'b1, 3'b000, 64'h11, 64'h55);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_MemWrite && n < 10);
    chk("rst_mid_reach_write", 64'(bus.mem_MemWrite), 64'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_memwrite",   64'(bus.mem_MemWrite), 64'd0);
    chk("rst_mid_memread",    64'(bus.mem_MemRead),  64'd0);
    chk("rst_mid_ready",      64'(bus.req_ready),    64'd1);
    chk("rst_mid_resp_valid", 64'(bus.resp_valid),   64'd0);
    chk("rst_mid_rdata",      bus.resp_rdata,        64'd0);
    chk("rst_mid_err",        64'(bus.resp_err),     64'd0);
    chk("rst_mid_address",    bus.mem_address,       64'd0);
    chk("rst_mid_wdata",      bus.mem_WriteData,     64'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_req(1'b0, 3'b011, 64'h10, 64'd0);
    chk("ld_after_rst", last_rdata, 64'h8877665544AB2211);

    for (int t = 0; t < 400; t++) begin
      w   = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 15);
      if (sel == 0)      a = {$urandom, $urandom};
      else if (sel == 1) a = 64'(8192 + $urandom_range(0, 64));
      else               a = 64'($urandom_range(0, 8191));
      if (sel >= 4) begin
        mask = (64'd1 << f3[1:0]) - 64'd1;
        a    = a & ~mask;
      end
      do_req(w, f3, a, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
